// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-bank write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  // One write-back request: destination index plus the value to write.
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // Identifies which requester won the most recent conflict.
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  // One-hot mask for a register index; index 0 never produces a bit,
  // since x0 is hardwired zero and must never be tracked.
  function automatic logic [NREG-1:0] reg_mask(input logic [AW-1:0] idx);
    logic [NREG-1:0] m;
    m = '0;
    if (idx != '0) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-way round-robin arbiter between ALU and load write-back requesters.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A requester keeps rd/data stable while valid && !ready. ready is
// combinational from valid and last_grant, is never asserted for both
// requesters in one cycle, and is held low while rst is high.
module wb_rr_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   alu_valid,
  input  logic   mem_valid,
  output logic   alu_ready,
  output logic   mem_ready,
  output grant_e last_grant
);

  grant_e last_grant_q;
  grant_e last_grant_d;
  logic   conflict;

  assign last_grant = last_grant_q;
  assign conflict   = alu_valid && mem_valid;

  // Grant decode and next priority state; priority only moves on a conflict.
  always_comb begin
    alu_ready    = 1'b0;
    mem_ready    = 1'b0;
    last_grant_d = last_grant_q;
    if (!rst) begin
      alu_ready = alu_valid && (!mem_valid || (last_grant_q == GNT_MEM));
      mem_ready = mem_valid && (!alu_valid || (last_grant_q == GNT_ALU));
      if (conflict) begin
        last_grant_d = alu_ready ? GNT_ALU : GNT_MEM;
      end
    end
  end

  // Priority register; resets to MEM so the ALU wins the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GNT_MEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the single write port of the register bank: arbitrates ALU and
// load write-backs, registers the winning write, and keeps a per-register
// pending scoreboard so decode can stall on RAW hazards.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            hazard,
  output logic [NREG-1:0] pending,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  grant_e          last_grant;
  wb_req_t         win_req;
  logic            accept;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] pending_q;

  wb_rr_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .mem_valid  (mem_valid),
    .alu_ready  (alu_ready),
    .mem_ready  (mem_ready),
    .last_grant (last_grant)
  );

  // Select the accepted request; at most one ready is high at a time.
  always_comb begin
    win_req = '0;
    accept  = alu_ready || mem_ready;
    if (alu_ready) begin
      win_req.rd   = alu_rd;
      win_req.data = alu_data;
    end else if (mem_ready) begin
      win_req.rd   = mem_rd;
      win_req.data = mem_data;
    end
  end

  // Scoreboard masks; applying set after clear makes a same-edge set win.
  always_comb begin
    set_mask = issue_valid ? reg_mask(issue_rd) : '0;
    clr_mask = accept ? reg_mask(win_req.rd) : '0;
  end

  // Registered write toward the bank; writes to x0 complete but never strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= accept && (win_req.rd != '0);
      if (accept) begin
        rf_waddr <= win_req.rd;
        rf_wdata <= win_req.data;
      end
    end
  end

  // Pending scoreboard update: clear on accepted write-back, set on issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_mask) | set_mask;
    end
  end

  assign pending = pending_q;

  // RAW hazard on either source; x0 never hazards.
  assign hazard = ((rs1 != '0) && pending_q[rs1]) ||
                  ((rs2 != '0) && pending_q[rs2]);

  // The priority state is kept visible for checker binding.
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic            clk;
  logic            rst;
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            hazard;
  logic [NREG-1:0] pending;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  int n_checks;
  int n_fails;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .hazard      (hazard),
    .pending     (pending),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    mem_valid   = 1'b0;
    mem_rd      = '0;
    mem_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1         = '0;
    rs2         = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle_inputs();
    rst = 1'b1;

    // 1. Reset
    step();
    step();
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", rf_wdata, 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    alu_rd    = 5'd3;
    mem_rd    = 5'd4;
    settle();
    check("rst_alu_ready", 64'(alu_ready), 64'd0);
    check("rst_mem_ready", 64'(mem_ready), 64'd0);
    step();
    check("rst_no_write", 64'(rf_we), 64'd0);
    idle_inputs();
    rst = 1'b0;
    step();

    // 2. ALU only
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 64'hDEAD_BEEF;
    settle();
    check("alu_only_ready", 64'(alu_ready), 64'd1);
    check("alu_only_mem_ready", 64'(mem_ready), 64'd0);
    step();
    alu_valid = 1'b0;
    check("alu_only_we", 64'(rf_we), 64'd1);
    check("alu_only_waddr", 64'(rf_waddr), 64'd5);
    check("alu_only_wdata", rf_wdata, 64'hDEAD_BEEF);
    step();
    check("alu_only_we_drop", 64'(rf_we), 64'd0);

    // 3. Conflict x3: ALU, MEM, ALU
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h22;
    settle();
    check("cf1_alu_ready", 64'(alu_ready), 64'd1);
    check("cf1_mem_ready", 64'(mem_ready), 64'd0);
    step();
    check("cf1_waddr", 64'(rf_waddr), 64'd1);
    check("cf1_wdata", rf_wdata, 64'h11);
    check("cf2_mem_ready", 64'(mem_ready), 64'd1);
    check("cf2_alu_ready", 64'(alu_ready), 64'd0);
    step();
    check("cf2_we", 64'(rf_we), 64'd1);
    check("cf2_waddr", 64'(rf_waddr), 64'd2);
    check("cf2_wdata", rf_wdata, 64'h22);
    check("cf3_alu_ready", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    check("cf3_we", 64'(rf_we), 64'd1);
    check("cf3_waddr", 64'(rf_waddr), 64'd1);
    step();
    check("cf_we_drop", 64'(rf_we), 64'd0);

    // 4. Scoreboard set, hazard, clear by MEM write-back
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    check("sb_pending_set", 64'(pending), 64'h80);
    rs1 = 5'd7;
    settle();
    check("sb_hazard_rs1", 64'(hazard), 64'd1);
    rs1 = 5'd0; rs2 = 5'd7;
    settle();
    check("sb_hazard_rs2", 64'(hazard), 64'd1);
    rs2 = 5'd6;
    settle();
    check("sb_no_hazard_other", 64'(hazard), 64'd0);
    rs1 = 5'd7;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h77;
    settle();
    check("sb_mem_ready", 64'(mem_ready), 64'd1);
    step();
    mem_valid = 1'b0;
    check("sb_pending_clr", 64'(pending), 64'd0);
    check("sb_hazard_clr", 64'(hazard), 64'd0);
    check("sb_wb_waddr", 64'(rf_waddr), 64'd7);
    check("sb_wb_wdata", rf_wdata, 64'h77);
    rs1 = 5'd0; rs2 = 5'd0;

    // 5. Same-edge set and clear on register 9: set wins
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    check("col_pending_pre", 64'(pending), 64'h200);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
    settle();
    check("col_alu_ready", 64'(alu_ready), 64'd1);
    step();
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    check("col_pending_kept", 64'(pending), 64'h200);
    check("col_we", 64'(rf_we), 64'd1);
    check("col_waddr", 64'(rf_waddr), 64'd9);
    check("col_wdata", rf_wdata, 64'h99);
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 64'h9A;
    step();
    mem_valid = 1'b0;
    check("col_pending_clr", 64'(pending), 64'd0);

    // 6. x0 handling
    issue_valid = 1'b1; issue_rd = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h5;
    settle();
    check("x0_alu_ready", 64'(alu_ready), 64'd1);
    step();
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    check("x0_pending", 64'(pending), 64'd0);
    check("x0_no_we", 64'(rf_we), 64'd0);
    settle();
    check("x0_hazard", 64'(hazard), 64'd0);

    // 6b. Reset mid-stream drops the in-flight write and pending bits
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
    issue_valid = 1'b1; issue_rd = 5'd4;
    step();
    issue_valid = 1'b0;
    check("mid_we_before_rst", 64'(rf_we), 64'd1);
    check("mid_pending_before_rst", 64'(pending), 64'h10);
    rst = 1'b1;
    settle();
    check("mid_rst_alu_ready", 64'(alu_ready), 64'd0);
    step();
    check("mid_rst_we", 64'(rf_we), 64'd0);
    check("mid_rst_pending", 64'(pending), 64'd0);
    alu_valid = 1'b0;
    rst = 1'b0;
    step();
    check("post_rst_we", 64'(rf_we), 64'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
